// File: rtl/input_cond_pkg.sv
// rtl/input_cond_pkg.sv - shared state encoding and default timing constants for input conditioning
package input_cond_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_e;

    localparam int DEBOUNCE_DEFAULT = 328;
    localparam int LONG_DEFAULT     = 65536;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one pad: 2-flop sync, debounce FSM, optional long-press detection
module debounce_channel
    import input_cond_pkg::*;
#(
    parameter bit HAS_LONG        = 1'b0,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int LONG_CYCLES     = LONG_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pad_ni,
    output logic accept_o,
    output logic short_o,
    output logic long_o
);

    localparam int              DW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0]   DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam bit              DEB_ONE  = (DEBOUNCE_CYCLES == 1);

    logic [1:0]    sync_q;
    logic          s;
    state_e        state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          accept_q, accept_d;
    logic          release_d;

    // Stored inverted so that the reset value 0 means "inactive".
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], ~pad_ni};
        end
    end

    assign s = sync_q[1];

    // The count includes the sample that left the stable state, so the
    // transition is taken on the DEBOUNCE_CYCLES-th consecutive sample.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept_d  = 1'b0;
        release_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s) begin
                    if (DEB_ONE) begin
                        state_d  = ST_PRESSED;
                        accept_d = 1'b1;
                    end else begin
                        state_d = ST_PRESS_WAIT;
                        cnt_d   = DW'(1);
                    end
                end
            end
            ST_PRESS_WAIT: begin
                if (!s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d  = ST_PRESSED;
                    cnt_d    = '0;
                    accept_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            ST_PRESSED: begin
                if (!s) begin
                    if (DEB_ONE) begin
                        state_d   = ST_IDLE;
                        release_d = 1'b1;
                    end else begin
                        state_d = ST_RELEASE_WAIT;
                        cnt_d   = DW'(1);
                    end
                end
            end
            default: begin
                if (s) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            accept_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            accept_q <= accept_d;
        end
    end

    assign accept_o = accept_q;

    generate
        if (HAS_LONG) begin : g_long
            localparam int            HW        = $clog2(LONG_CYCLES + 1);
            localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
            localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

            logic [HW-1:0] hold_q, hold_d;
            logic          long_done_q, long_done_d;
            logic          short_q, short_d;
            logic          long_q;
            logic          holding;
            logic          long_hit;

            assign holding  = (state_q == ST_PRESSED) || (state_q == ST_RELEASE_WAIT);
            assign long_hit = holding && (hold_q == HOLD_LAST);

            // Hold time survives release bounce and only restarts from IDLE.
            always_comb begin
                hold_d      = hold_q;
                long_done_d = long_done_q;
                if (!holding) begin
                    hold_d = '0;
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + HW'(1);
                end
                if (state_d == ST_IDLE) begin
                    long_done_d = 1'b0;
                end else if (long_hit) begin
                    long_done_d = 1'b1;
                end
                short_d = release_d && !long_done_q && !long_hit;
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    hold_q      <= '0;
                    long_done_q <= 1'b0;
                    short_q     <= 1'b0;
                    long_q      <= 1'b0;
                end else begin
                    hold_q      <= hold_d;
                    long_done_q <= long_done_d;
                    short_q     <= short_d;
                    long_q      <= long_hit;
                end
            end

            assign short_o = short_q;
            assign long_o  = long_q;
        end else begin : g_no_long
            logic short_q;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    short_q <= 1'b0;
                end else begin
                    short_q <= release_d;
                end
            end

            assign short_o = short_q;
            assign long_o  = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - conditions four active-low pads into clean single-cycle event pulses
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int LONG_CYCLES     = LONG_DEFAULT
) (
    input  logic Clock,
    input  logic nReset,
    input  logic nFork,
    input  logic nCrank,
    input  logic nMode,
    input  logic nTrip,
    output logic ForkPulse,
    output logic CrankPulse,
    output logic ModeShort,
    output logic ModeLong,
    output logic TripShort,
    output logic TripLong
);

    logic fork_rel, fork_long;
    logic crank_rel, crank_long;
    logic mode_acc, trip_acc;
    logic unused_events;

    debounce_channel #(
        .HAS_LONG(1'b0), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .LONG_CYCLES(LONG_CYCLES)
    ) u_fork (
        .clk_i(Clock), .rst_ni(nReset), .pad_ni(nFork),
        .accept_o(ForkPulse), .short_o(fork_rel), .long_o(fork_long)
    );

    debounce_channel #(
        .HAS_LONG(1'b0), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .LONG_CYCLES(LONG_CYCLES)
    ) u_crank (
        .clk_i(Clock), .rst_ni(nReset), .pad_ni(nCrank),
        .accept_o(CrankPulse), .short_o(crank_rel), .long_o(crank_long)
    );

    debounce_channel #(
        .HAS_LONG(1'b1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .LONG_CYCLES(LONG_CYCLES)
    ) u_mode (
        .clk_i(Clock), .rst_ni(nReset), .pad_ni(nMode),
        .accept_o(mode_acc), .short_o(ModeShort), .long_o(ModeLong)
    );

    debounce_channel #(
        .HAS_LONG(1'b1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .LONG_CYCLES(LONG_CYCLES)
    ) u_trip (
        .clk_i(Clock), .rst_ni(nReset), .pad_ni(nTrip),
        .accept_o(trip_acc), .short_o(TripShort), .long_o(TripLong)
    );

    // Sensors only report contacts; buttons only report release/hold.
    assign unused_events = &{1'b0, fork_rel, fork_long, crank_rel, crank_long, mode_acc, trip_acc};

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - directed self-checking bench for input_conditioner
module tb_input_conditioner;
    import input_cond_pkg::*;

    logic Clock = 1'b0;
    logic nReset = 1'b0;
    logic nFork = 1'b1, nCrank = 1'b1, nMode = 1'b1, nTrip = 1'b1;
    logic ForkPulse, CrankPulse, ModeShort, ModeLong, TripShort, TripLong;

    int tests_run = 0;
    int tests_failed = 0;

    input_conditioner #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(20)) dut (
        .Clock(Clock), .nReset(nReset),
        .nFork(nFork), .nCrank(nCrank), .nMode(nMode), .nTrip(nTrip),
        .ForkPulse(ForkPulse), .CrankPulse(CrankPulse),
        .ModeShort(ModeShort), .ModeLong(ModeLong),
        .TripShort(TripShort), .TripLong(TripLong)
    );

    always #5 Clock = ~Clock;

    // 0 fork, 1 crank, 2 mode short, 3 mode long, 4 trip short, 5 trip long
    int   cyc = 0;
    int   cnt [6];
    int   at  [6];
    int   base[6];
    int   dbl = 0;
    logic [5:0] outs, prev_outs = '0;
    string names[6] = '{"ForkPulse", "CrankPulse", "ModeShort", "ModeLong", "TripShort", "TripLong"};

    assign outs = {TripLong, TripShort, ModeLong, ModeShort, CrankPulse, ForkPulse};

    initial for (int i = 0; i < 6; i++) begin cnt[i] = 0; at[i] = -1; base[i] = 0; end

    always @(posedge Clock) cyc = cyc + 1;

    always @(negedge Clock) begin
        for (int i = 0; i < 6; i++) begin
            if (outs[i]) begin
                cnt[i] = cnt[i] + 1;
                at[i]  = cyc;
                if (prev_outs[i]) dbl = dbl + 1;
            end
        end
        prev_outs = outs;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic mark();
        for (int i = 0; i < 6; i++) base[i] = cnt[i];
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        tick(3);
        tests_run++;
        if (outs !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b expected %b", outs, 6'b0);
        end
        tests_run++;
        if (dut.u_trip.state_q !== ST_IDLE) begin
            tests_failed++;
            $display("FAIL reset_state: got %0d expected %0d", dut.u_trip.state_q, ST_IDLE);
        end
        nReset = 1'b1;
        tick(4);
        tests_run++;
        if (outs !== 6'b0) begin
            tests_failed++;
            $display("FAIL idle_outputs: got %b expected %b", outs, 6'b0);
        end
    endtask

    task automatic test_fork();
        int e0;
        mark();
        e0 = cyc + 1;
        nFork = 1'b0;
        tick(10);
        nFork = 1'b1;
        tick(15);
        tests_run++;
        if (cnt[0] - base[0] !== 1) begin
            tests_failed++;
            $display("FAIL fork_count: got %0d expected 1", cnt[0] - base[0]);
        end
        tests_run++;
        if (at[0] !== e0 + 5) begin
            tests_failed++;
            $display("FAIL fork_latency: got edge %0d expected %0d", at[0], e0 + 5);
        end
        for (int i = 1; i < 6; i++) begin
            tests_run++;
            if (cnt[i] - base[i] !== 0) begin
                tests_failed++;
                $display("FAIL fork_other_%s: got %0d expected 0", names[i], cnt[i] - base[i]);
            end
        end
    endtask

    task automatic test_glitch();
        mark();
        nCrank = 1'b0;
        tick(3);
        nCrank = 1'b1;
        tick(12);
        tests_run++;
        if (cnt[1] - base[1] !== 0) begin
            tests_failed++;
            $display("FAIL glitch_crank: got %0d expected 0", cnt[1] - base[1]);
        end
        tests_run++;
        if (dut.u_crank.state_q !== ST_IDLE) begin
            tests_failed++;
            $display("FAIL glitch_state: got %0d expected %0d", dut.u_crank.state_q, ST_IDLE);
        end
    endtask

    task automatic test_back_to_back();
        int e0;
        mark();
        e0 = cyc + 1;
        nFork = 1'b0;
        tick(4);
        nFork = 1'b1;
        tick(4);
        nFork = 1'b0;
        tick(4);
        nFork = 1'b1;
        tick(15);
        tests_run++;
        if (cnt[0] - base[0] !== 2) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d expected 2", cnt[0] - base[0]);
        end
        tests_run++;
        if (at[0] !== e0 + 13) begin
            tests_failed++;
            $display("FAIL b2b_second_latency: got edge %0d expected %0d", at[0], e0 + 13);
        end
    endtask

    task automatic test_short_press();
        int r0;
        mark();
        nMode = 1'b0;
        tick(10);
        r0 = cyc + 1;
        nMode = 1'b1;
        tick(15);
        tests_run++;
        if (cnt[2] - base[2] !== 1) begin
            tests_failed++;
            $display("FAIL short_count: got %0d expected 1", cnt[2] - base[2]);
        end
        tests_run++;
        if (at[2] !== r0 + 5) begin
            tests_failed++;
            $display("FAIL short_latency: got edge %0d expected %0d", at[2], r0 + 5);
        end
        tests_run++;
        if (cnt[3] - base[3] !== 0) begin
            tests_failed++;
            $display("FAIL short_no_long: got %0d expected 0", cnt[3] - base[3]);
        end
    endtask

    task automatic test_long_press();
        int e0;
        mark();
        e0 = cyc + 1;
        nTrip = 1'b0;
        tick(40);
        nTrip = 1'b1;
        tick(15);
        tests_run++;
        if (cnt[5] - base[5] !== 1) begin
            tests_failed++;
            $display("FAIL long_count: got %0d expected 1", cnt[5] - base[5]);
        end
        tests_run++;
        if (at[5] !== e0 + 25) begin
            tests_failed++;
            $display("FAIL long_latency: got edge %0d expected %0d", at[5], e0 + 25);
        end
        tests_run++;
        if (cnt[4] - base[4] !== 0) begin
            tests_failed++;
            $display("FAIL long_no_short: got %0d expected 0", cnt[4] - base[4]);
        end
    endtask

    task automatic test_simultaneous();
        int e0, r0;
        int exp_cnt[6];
        int exp_at[6];
        mark();
        e0 = cyc + 1;
        {nFork, nCrank, nMode, nTrip} = 4'b0000;
        tick(12);
        r0 = cyc + 1;
        {nFork, nCrank, nMode, nTrip} = 4'b1111;
        tick(1);
        nMode = 1'b0;
        tick(2);
        nMode = 1'b1;
        tick(15);
        exp_cnt = '{1, 1, 1, 0, 1, 0};
        exp_at  = '{e0 + 5, e0 + 5, r0 + 8, -1, r0 + 5, -1};
        for (int i = 0; i < 6; i++) begin
            tests_run++;
            if (cnt[i] - base[i] !== exp_cnt[i]) begin
                tests_failed++;
                $display("FAIL simul_count_%s: got %0d expected %0d", names[i], cnt[i] - base[i], exp_cnt[i]);
            end
            if (exp_cnt[i] == 1) begin
                tests_run++;
                if (at[i] !== exp_at[i]) begin
                    tests_failed++;
                    $display("FAIL simul_latency_%s: got edge %0d expected %0d", names[i], at[i], exp_at[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        int e1;
        mark();
        nTrip = 1'b0;
        tick(15);
        nReset = 1'b0;
        tick(1);
        tests_run++;
        if (outs !== 6'b0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got %b expected %b", outs, 6'b0);
        end
        tick(1);
        nReset = 1'b1;
        e1 = cyc + 1;
        tick(30);
        tests_run++;
        if (cnt[5] - base[5] !== 1) begin
            tests_failed++;
            $display("FAIL midreset_long_count: got %0d expected 1", cnt[5] - base[5]);
        end
        tests_run++;
        if (at[5] !== e1 + 25) begin
            tests_failed++;
            $display("FAIL midreset_long_latency: got edge %0d expected %0d", at[5], e1 + 25);
        end
        nTrip = 1'b1;
        tick(15);
        tests_run++;
        if (cnt[4] - base[4] !== 0) begin
            tests_failed++;
            $display("FAIL midreset_no_short: got %0d expected 0", cnt[4] - base[4]);
        end
    endtask

    initial begin
        test_reset();
        test_fork();
        test_glitch();
        test_back_to_back();
        test_short_press();
        test_long_press();
        test_simultaneous();
        test_reset_mid_hold();
        tests_run++;
        if (dbl !== 0) begin
            tests_failed++;
            $display("FAIL single_cycle_pulses: got %0d repeats expected 0", dbl);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
